// File: rtl/cc_pkg.sv
// Shared cache-controller types for the memory-side fill path.
// Holds the beat and line geometry, the line/FIFO-entry types the serializer
// also uses, and the deserializer FSM state encoding.
package cc_pkg;

    localparam int unsigned BEAT_W = 64;
    localparam int unsigned BEATS  = 8;
    localparam int unsigned LINE_W = BEAT_W * BEATS;
    localparam int unsigned OFS_W  = 6;
    localparam int unsigned FIFO_W = OFS_W + LINE_W;

    typedef logic [LINE_W-1:0] line_t;

    // The offset sits in the top bits, so the packed entry is {offset, line}.
    typedef struct packed {
        logic [OFS_W-1:0] offset;
        line_t            line;
    } fifo_entry_t;

    typedef enum logic [1:0] {
        StIdle,
        StFill,
        StPush
    } state_e;

endpackage

// File: rtl/cc_deserializer_if.sv
// Bundles the handshake and data signals of the line deserializer.
//   request : req_valid_i, req_offset_i -> req_ready_o
//   memory  : mem_rdata_i, mem_rlast_i, mem_rvalid_i -> mem_rready_o
//   fill    : fill_valid_o, fill_data_o (data-array write)
//   fifo    : fifo_full_i -> fifo_wren_o, fifo_wdata_o
//   status  : protocol_err_o
// The slave modport is the deserializer; master is its environment.
interface cc_deserializer_if;
    import cc_pkg::*;

    logic             req_valid_i;
    logic [OFS_W-1:0] req_offset_i;
    logic             req_ready_o;

    logic [BEAT_W-1:0] mem_rdata_i;
    logic              mem_rlast_i;
    logic              mem_rvalid_i;
    logic              mem_rready_o;

    logic  fill_valid_o;
    line_t fill_data_o;

    logic        fifo_full_i;
    logic        fifo_wren_o;
    fifo_entry_t fifo_wdata_o;

    logic protocol_err_o;

    modport slave (
        input  req_valid_i, req_offset_i, mem_rdata_i, mem_rlast_i, mem_rvalid_i, fifo_full_i,
        output req_ready_o, mem_rready_o, fill_valid_o, fill_data_o, fifo_wren_o,
               fifo_wdata_o, protocol_err_o
    );

    modport master (
        output req_valid_i, req_offset_i, mem_rdata_i, mem_rlast_i, mem_rvalid_i, fifo_full_i,
        input  req_ready_o, mem_rready_o, fill_valid_o, fill_data_o, fifo_wren_o,
               fifo_wdata_o, protocol_err_o
    );

endinterface

// File: rtl/cc_deserializer.sv
// Memory-side fill stage: gathers the eight 64-bit beats of a wrapping,
// critical-word-first burst into a 512-bit line, then pushes {offset, line}
// into the line FIFO while strobing the same line to the data array.
// Ports:
//   clk - clock
//   rst - synchronous active-high reset
//   bus - cc_deserializer_if.slave (request, memory read, fill, FIFO, status)
module cc_deserializer
    import cc_pkg::*;
(
    input logic              clk,
    input logic              rst,
    cc_deserializer_if.slave bus
);

    state_e r_state;
    state_e w_state_next;

    logic [2:0]                    r_cnt;
    logic [2:0]                    r_start;
    logic [OFS_W-1:0]              r_offset;
    logic [BEATS-1:0][BEAT_W-1:0]  r_words;
    logic                          r_perr;

    logic       w_req_hs;
    logic       w_beat_hs;
    logic       w_last_beat;
    logic [2:0] w_widx;

    assign w_req_hs    = (r_state == StIdle) && bus.req_valid_i;
    assign w_beat_hs   = (r_state == StFill) && bus.mem_rvalid_i;
    assign w_last_beat = (r_cnt == 3'(BEATS - 1));
    // Wrapping burst: beat n lands in word (start + n) mod 8 via 3-bit overflow.
    assign w_widx      = r_start + r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= StIdle;
            r_cnt    <= 3'd0;
            r_start  <= 3'd0;
            r_offset <= '0;
            r_perr   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            // rlast is only checked, never used to end the burst.
            r_perr  <= w_beat_hs && (bus.mem_rlast_i != w_last_beat);
            if (w_req_hs) begin
                r_offset <= bus.req_offset_i;
                r_start  <= bus.req_offset_i[OFS_W-1:3];
                r_cnt    <= 3'd0;
            end else if (w_beat_hs) begin
                r_cnt <= r_cnt + 3'd1;
            end
        end
    end

    // Line buffer carries no reset; its contents only matter once all beats land.
    always_ff @(posedge clk) begin
        if (w_beat_hs) begin
            r_words[w_widx] <= bus.mem_rdata_i;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: if (bus.req_valid_i) w_state_next = StFill;
            StFill: if (bus.mem_rvalid_i && w_last_beat) w_state_next = StPush;
            StPush: if (!bus.fifo_full_i) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        bus.req_ready_o         = (r_state == StIdle);
        bus.mem_rready_o        = (r_state == StFill);
        bus.fifo_wren_o         = (r_state == StPush) && !bus.fifo_full_i;
        bus.fill_valid_o        = (r_state == StPush) && !bus.fifo_full_i;
        bus.fill_data_o         = r_words;
        bus.fifo_wdata_o.offset = r_offset;
        bus.fifo_wdata_o.line   = r_words;
        bus.protocol_err_o      = r_perr;
    end

endmodule

// File: tb/tb_cc_deserializer.sv
// Self-checking bench for cc_deserializer: directed scenarios followed by
// randomized line fills, all compared against a word-placement model.
module tb_cc_deserializer;
    import cc_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cc_deserializer_if bus ();

    cc_deserializer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Scenario knobs consumed by run_line.
    logic [63:0] tb_beats [8];
    logic        tb_last  [8];
    int          tb_gap   [8];
    int          tb_full;
    int          tb_idle;

    task automatic check(input string tag, input logic [517:0] obs, input logic [517:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_default_beats();
        for (int k = 0; k < 8; k++) begin
            tb_beats[k] = 64'h1111_1111_1111_1111 * 64'(k + 1);
            tb_last[k]  = (k == 7);
            tb_gap[k]   = 0;
        end
        tb_full = 0;
        tb_idle = 0;
    endtask

    // One complete miss: optional idle beats, request, eight beats, push.
    task automatic run_line(input logic [5:0] ofs);
        logic [511:0] exp_line;
        logic         perr_exp;
        int           start;
        start = int'(ofs) / 8;
        for (int k = 0; k < 8; k++) begin
            exp_line[64*((start + k) % 8) +: 64] = tb_beats[k];
        end
        perr_exp = 1'b0;

        for (int i = 0; i < tb_idle; i++) begin
            @(negedge clk);
            bus.mem_rvalid_i = 1'b1;
            bus.mem_rdata_i  = {$urandom, $urandom};
            bus.mem_rlast_i  = 1'b0;
            #1;
            check("idle_rready", 518'(bus.mem_rready_o), 518'(0));
            check("idle_req_ready", 518'(bus.req_ready_o), 518'(1));
        end

        @(negedge clk);
        bus.mem_rvalid_i = 1'b0;
        bus.req_valid_i  = 1'b1;
        bus.req_offset_i = ofs;
        #1;
        check("req_ready", 518'(bus.req_ready_o), 518'(1));

        for (int k = 0; k < 8; k++) begin
            for (int g = 0; g < tb_gap[k]; g++) begin
                @(negedge clk);
                bus.req_valid_i  = 1'b0;
                bus.mem_rvalid_i = 1'b0;
                #1;
                check("fill_rready_gap", 518'(bus.mem_rready_o), 518'(1));
                check("perr_gap", 518'(bus.protocol_err_o), 518'(perr_exp));
                perr_exp = 1'b0;
            end
            @(negedge clk);
            bus.req_valid_i  = 1'b0;
            bus.mem_rvalid_i = 1'b1;
            bus.mem_rdata_i  = tb_beats[k];
            bus.mem_rlast_i  = tb_last[k];
            #1;
            check("fill_rready", 518'(bus.mem_rready_o), 518'(1));
            check("fill_req_ready", 518'(bus.req_ready_o), 518'(0));
            check("perr_beat", 518'(bus.protocol_err_o), 518'(perr_exp));
            perr_exp = (tb_last[k] != (k == 7));
        end

        // Stall with junk beats and a pending request offered; none may be taken.
        for (int i = 0; i < tb_full; i++) begin
            @(negedge clk);
            bus.fifo_full_i  = 1'b1;
            bus.mem_rvalid_i = 1'b1;
            bus.mem_rdata_i  = {$urandom, $urandom};
            bus.mem_rlast_i  = 1'b0;
            bus.req_valid_i  = 1'b1;
            bus.req_offset_i = 6'($urandom);
            #1;
            check("stall_wren", 518'(bus.fifo_wren_o), 518'(0));
            check("stall_fill_valid", 518'(bus.fill_valid_o), 518'(0));
            check("stall_rready", 518'(bus.mem_rready_o), 518'(0));
            check("stall_req_ready", 518'(bus.req_ready_o), 518'(0));
            check("stall_perr", 518'(bus.protocol_err_o), 518'(perr_exp));
            perr_exp = 1'b0;
        end

        @(negedge clk);
        bus.fifo_full_i  = 1'b0;
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rlast_i  = 1'b0;
        bus.req_valid_i  = 1'b1;
        bus.req_offset_i = 6'($urandom);
        #1;
        check("push_wren", 518'(bus.fifo_wren_o), 518'(1));
        check("push_fill_valid", 518'(bus.fill_valid_o), 518'(1));
        check("push_req_ready", 518'(bus.req_ready_o), 518'(0));
        check("push_wdata", 518'(bus.fifo_wdata_o), {ofs, exp_line});
        check("push_fill_data", 518'(bus.fill_data_o), 518'(exp_line));
        check("push_perr", 518'(bus.protocol_err_o), 518'(perr_exp));

        // Request offered during the push must not have been taken.
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        #1;
        check("post_wren", 518'(bus.fifo_wren_o), 518'(0));
        check("post_req_ready", 518'(bus.req_ready_o), 518'(1));
        check("post_perr", 518'(bus.protocol_err_o), 518'(0));
    endtask

    initial begin
        rst              = 1'b1;
        bus.req_valid_i  = 1'b0;
        bus.req_offset_i = '0;
        bus.mem_rdata_i  = '0;
        bus.mem_rlast_i  = 1'b0;
        bus.mem_rvalid_i = 1'b0;
        bus.fifo_full_i  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_req_ready", 518'(bus.req_ready_o), 518'(1));
        check("rst_rready", 518'(bus.mem_rready_o), 518'(0));
        check("rst_wren", 518'(bus.fifo_wren_o), 518'(0));
        check("rst_fill_valid", 518'(bus.fill_valid_o), 518'(0));
        check("rst_perr", 518'(bus.protocol_err_o), 518'(0));

        // Basic fill, then critical-word wrap.
        set_default_beats();
        run_line(6'h00);
        set_default_beats();
        run_line(6'h2A);

        // FIFO backpressure.
        set_default_beats();
        tb_full = 5;
        run_line(6'h13);

        // Sparse beats with rvalid pulses before the request.
        set_default_beats();
        for (int k = 0; k < 8; k++) tb_gap[k] = 2;
        tb_idle = 3;
        run_line(6'h31);

        // rlast early on beat 6 and missing on beat 8.
        set_default_beats();
        tb_last[5] = 1'b1;
        tb_last[7] = 1'b0;
        run_line(6'h07);

        // Reset after four beats abandons the line.
        @(negedge clk);
        bus.req_valid_i  = 1'b1;
        bus.req_offset_i = 6'h10;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.req_valid_i  = 1'b0;
            bus.mem_rvalid_i = 1'b1;
            bus.mem_rdata_i  = {$urandom, $urandom};
            bus.mem_rlast_i  = 1'b0;
        end
        @(negedge clk);
        bus.mem_rvalid_i = 1'b0;
        rst              = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_req_ready", 518'(bus.req_ready_o), 518'(1));
        check("mid_rst_rready", 518'(bus.mem_rready_o), 518'(0));
        check("mid_rst_wren", 518'(bus.fifo_wren_o), 518'(0));
        check("mid_rst_fill_valid", 518'(bus.fill_valid_o), 518'(0));
        check("mid_rst_perr", 518'(bus.protocol_err_o), 518'(0));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("mid_rst_idle_wren", 518'(bus.fifo_wren_o), 518'(0));
        end
        set_default_beats();
        run_line(6'h08);

        // Randomized lines.
        for (int t = 0; t < 25; t++) begin
            for (int k = 0; k < 8; k++) begin
                tb_beats[k] = {$urandom, $urandom};
                tb_last[k]  = (k == 7) ^ ($urandom_range(0, 9) == 0);
                tb_gap[k]   = int'($urandom_range(0, 2));
            end
            tb_full = int'($urandom_range(0, 3));
            tb_idle = int'($urandom_range(0, 2));
            run_line(6'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
